// File: rtl/disc_rx_pkg.sv
// Shared types and constants for the discriminator receive path:
// readout FSM states, channel-select encoding and default sizing.
package disc_rx_pkg;

    localparam int DEF_CNT_W       = 12;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MIN_WIDTH   = 2;

    localparam logic SEL_LOCAL = 1'b0;
    localparam logic SEL_SUM   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OUT_L = 2'd1,
        OUT_S = 2'd2
    } rd_state_e;

endpackage

// File: rtl/disc_pulse_qualifier.sv
// One discriminator channel: brings the async input into the clk domain,
// measures how long it stays high, and emits a single-cycle hit strobe
// once per pulse that lasts at least MIN_WIDTH synchronized cycles.
module disc_pulse_qualifier
    import disc_rx_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MIN_WIDTH   = DEF_MIN_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic disc_i,
    output logic hit_o
);

    // 4 bits cover the full MIN_WIDTH range of 1..15.
    localparam int              RUN_W   = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_WIDTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [RUN_W-1:0]       run_q;
    logic [RUN_W-1:0]       run_d;
    logic                   synced;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], disc_i};
    assign synced = sync_q[SYNC_STAGES-1];

    // Run length of the current high pulse, parked at MIN_WIDTH so the strobe
    // cannot repeat until the input drops and the count clears.
    always_comb begin
        run_d = '0;
        if (synced) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        end
    end

    // Strobe on the cycle the run length reaches MIN_WIDTH.
    assign hit_o = synced && (run_q == RUN_MAX - RUN_W'(1));

    // Synchronizer chain and run counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            run_q  <= '0;
        end else begin
            sync_q <= sync_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/disc_hit_counter.sv
// Receiving end of the pixel discriminator interface. Qualified hits from
// the local and summing channels are counted while the shutter is open; a
// readout request snapshots both counts into shadows (clearing the live
// counters) and streams them out as two words while counting continues.
module disc_hit_counter
    import disc_rx_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MIN_WIDTH   = DEF_MIN_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             disc_local_i,
    input  logic             disc_sum_i,
    input  logic             shutter_i,
    input  logic             readout_req_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             rd_sel_o,
    output logic             rd_ovf_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating increment: holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != CNT_MAX)) ? c + CNT_W'(1) : c;
    endfunction

    // True when an increment is requested but the counter is already full.
    function automatic logic sat_ovf(input logic [CNT_W-1:0] c, input logic en);
        return en && (c == CNT_MAX);
    endfunction

    logic hit_l;
    logic hit_s;
    logic inc_l;
    logic inc_s;
    logic snap;

    logic [CNT_W-1:0] cnt_l_q, cnt_l_d, cnt_s_q, cnt_s_d;
    logic             ovf_l_q, ovf_l_d, ovf_s_q, ovf_s_d;
    logic [CNT_W-1:0] shd_l_q, shd_l_d, shd_s_q, shd_s_d;
    logic             shd_ovf_l_q, shd_ovf_l_d, shd_ovf_s_q, shd_ovf_s_d;

    rd_state_e        state_q, state_d;
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_sel_q, rd_sel_d;
    logic             rd_ovf_q, rd_ovf_d;
    logic             busy_q, busy_d;

    disc_pulse_qualifier #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_WIDTH   (MIN_WIDTH)
    ) u_qual_local (
        .clk    (clk),
        .rst_n  (rst_n),
        .disc_i (disc_local_i),
        .hit_o  (hit_l)
    );

    disc_pulse_qualifier #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_WIDTH   (MIN_WIDTH)
    ) u_qual_sum (
        .clk    (clk),
        .rst_n  (rst_n),
        .disc_i (disc_sum_i),
        .hit_o  (hit_s)
    );

    assign inc_l = hit_l && shutter_i;
    assign inc_s = hit_s && shutter_i;
    // Requests arriving during a transfer are ignored entirely.
    assign snap  = (state_q == IDLE) && readout_req_i;

    // Live counters and shadows; a hit in the snapshot cycle lands in the
    // shadow, and the live counter restarts from zero.
    always_comb begin
        cnt_l_d     = sat_inc(cnt_l_q, inc_l);
        cnt_s_d     = sat_inc(cnt_s_q, inc_s);
        ovf_l_d     = ovf_l_q | sat_ovf(cnt_l_q, inc_l);
        ovf_s_d     = ovf_s_q | sat_ovf(cnt_s_q, inc_s);
        shd_l_d     = shd_l_q;
        shd_s_d     = shd_s_q;
        shd_ovf_l_d = shd_ovf_l_q;
        shd_ovf_s_d = shd_ovf_s_q;
        if (snap) begin
            shd_l_d     = cnt_l_d;
            shd_s_d     = cnt_s_d;
            shd_ovf_l_d = ovf_l_d;
            shd_ovf_s_d = ovf_s_d;
            cnt_l_d     = '0;
            cnt_s_d     = '0;
            ovf_l_d     = 1'b0;
            ovf_s_d     = 1'b0;
        end
    end

    // Readout FSM next state; outputs are derived from the next state so they
    // can be registered without adding a cycle of latency.
    always_comb begin
        state_d    = state_q;
        rd_valid_d = 1'b0;
        rd_data_d  = '0;
        rd_sel_d   = SEL_LOCAL;
        rd_ovf_d   = 1'b0;
        case (state_q)
            IDLE:    if (readout_req_i) state_d = OUT_L;
            OUT_L:   if (rd_ready_i)    state_d = OUT_S;
            OUT_S:   if (rd_ready_i)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        case (state_d)
            OUT_L: begin
                rd_valid_d = 1'b1;
                rd_data_d  = shd_l_d;
                rd_sel_d   = SEL_LOCAL;
                rd_ovf_d   = shd_ovf_l_d;
            end
            OUT_S: begin
                rd_valid_d = 1'b1;
                rd_data_d  = shd_s_d;
                rd_sel_d   = SEL_SUM;
                rd_ovf_d   = shd_ovf_s_d;
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Counter, shadow and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_l_q     <= '0;
            cnt_s_q     <= '0;
            ovf_l_q     <= 1'b0;
            ovf_s_q     <= 1'b0;
            shd_l_q     <= '0;
            shd_s_q     <= '0;
            shd_ovf_l_q <= 1'b0;
            shd_ovf_s_q <= 1'b0;
        end else begin
            cnt_l_q     <= cnt_l_d;
            cnt_s_q     <= cnt_s_d;
            ovf_l_q     <= ovf_l_d;
            ovf_s_q     <= ovf_s_d;
            shd_l_q     <= shd_l_d;
            shd_s_q     <= shd_s_d;
            shd_ovf_l_q <= shd_ovf_l_d;
            shd_ovf_s_q <= shd_ovf_s_d;
        end
    end

    // FSM state and registered readout outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_sel_q   <= SEL_LOCAL;
            rd_ovf_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_sel_q   <= rd_sel_d;
            rd_ovf_q   <= rd_ovf_d;
            busy_q     <= busy_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_sel_o   = rd_sel_q;
    assign rd_ovf_o   = rd_ovf_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_disc_hit_counter.sv
// Bench for disc_hit_counter: a default-size instance and a CNT_W=4 instance
// share all inputs; expectations come from a pulse-level count model.
module tb_disc_hit_counter;

    localparam int MIN_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic disc_local = 1'b0;
    logic disc_sum = 1'b0;
    logic shutter = 1'b0;
    logic readout_req = 1'b0;
    logic rd_ready = 1'b0;

    logic        rd_valid, rd_sel, rd_ovf, busy;
    logic [11:0] rd_data;
    logic        rd_valid4, rd_sel4, rd_ovf4, busy4;
    logic [3:0]  rd_data4;

    int n_checks = 0;
    int n_fail = 0;
    int exp_l = 0;
    int exp_s = 0;

    always #5 clk = ~clk;

    disc_hit_counter dut (
        .clk(clk), .rst_n(rst_n), .disc_local_i(disc_local), .disc_sum_i(disc_sum),
        .shutter_i(shutter), .readout_req_i(readout_req), .rd_valid_o(rd_valid),
        .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_sel_o(rd_sel),
        .rd_ovf_o(rd_ovf), .busy_o(busy)
    );

    disc_hit_counter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .disc_local_i(disc_local), .disc_sum_i(disc_sum),
        .shutter_i(shutter), .readout_req_i(readout_req), .rd_valid_o(rd_valid4),
        .rd_ready_i(rd_ready), .rd_data_o(rd_data4), .rd_sel_o(rd_sel4),
        .rd_ovf_o(rd_ovf4), .busy_o(busy4)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one pulse per channel starting together; updates the count model.
    task automatic pulse(input int len_l, input int len_s, input bit sh, input int gap);
        int span;
        span = (len_l > len_s) ? len_l : len_s;
        shutter = sh;
        for (int i = 0; i < span; i++) begin
            disc_local = (i < len_l);
            disc_sum   = (i < len_s);
            @(negedge clk);
        end
        disc_local = 1'b0;
        disc_sum   = 1'b0;
        repeat (gap) @(negedge clk);
        if (sh && len_l >= MIN_W) exp_l++;
        if (sh && len_s >= MIN_W) exp_s++;
    endtask

    // Request a readout with ready high and collect both words from both DUTs.
    task automatic read_frame(output logic [11:0] ld, output logic lo, output logic ls,
                              output logic [11:0] sd, output logic so, output logic ss,
                              output logic [3:0] l4d, output logic l4o,
                              output logic [3:0] s4d, output logic s4o, output bit to);
        int n;
        to = 1'b0;
        rd_ready = 1'b1;
        readout_req = 1'b1;
        @(negedge clk);
        readout_req = 1'b0;
        n = 0;
        while (!rd_valid && n < 20) begin @(negedge clk); n++; end
        if (!rd_valid) to = 1'b1;
        ld = rd_data; lo = rd_ovf; ls = rd_sel; l4d = rd_data4; l4o = rd_ovf4;
        @(negedge clk);
        n = 0;
        while (!rd_valid && n < 20) begin @(negedge clk); n++; end
        if (!rd_valid) to = 1'b1;
        sd = rd_data; so = rd_ovf; ss = rd_sel; s4d = rd_data4; s4o = rd_ovf4;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", rd_valid); end
        n_checks++; if (rd_data !== 12'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", rd_data); end
        n_checks++; if (rd_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %0b want 0", rd_sel); end
        n_checks++; if (rd_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", rd_ovf); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_l = 0; exp_s = 0;
        for (int i = 0; i < 5; i++) pulse(4, 0, 1'b1, 6);
        rd_ready = 1'b1;
        readout_req = 1'b1;
        @(negedge clk);
        readout_req = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b1 || rd_sel !== 1'b0 || rd_data !== 12'(exp_l) || rd_ovf !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_word0 got v%0b s%0b d%0d o%0b b%0b want v1 s0 d%0d o0 b1",
                               rd_valid, rd_sel, rd_data, rd_ovf, busy, exp_l);
        end
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b1 || rd_sel !== 1'b1 || rd_data !== 12'(exp_s) || rd_ovf !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_word1 got v%0b s%0b d%0d o%0b b%0b want v1 s1 d%0d o0 b1",
                               rd_valid, rd_sel, rd_data, rd_ovf, busy, exp_s);
        end
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_data !== 12'd0) begin
            n_fail++; $display("FAIL basic_idle got v%0b b%0b d%0d want v0 b0 d0", rd_valid, busy, rd_data);
        end
        rd_ready = 1'b0;
        exp_l = 0; exp_s = 0;
    endtask

    task automatic test_min_width();
        logic [11:0] ld, sd; logic lo, ls, so, ss, l4o, s4o; logic [3:0] l4d, s4d; bit to;
        pulse(1, 0, 1'b1, 5);
        pulse(2, 0, 1'b1, 5);
        // Long pulse; snapshot on the edge just before its hit can land.
        disc_local = 1'b1;
        repeat (2) @(negedge clk);
        read_frame(ld, lo, ls, sd, so, ss, l4d, l4o, s4d, s4o, to);
        n_checks++; if (to || ld !== 12'(exp_l)) begin n_fail++; $display("FAIL minw_short got %0d want %0d to=%0b", ld, exp_l, to); end
        repeat (45) @(negedge clk);
        disc_local = 1'b0;
        repeat (5) @(negedge clk);
        exp_l = 1;
        read_frame(ld, lo, ls, sd, so, ss, l4d, l4o, s4d, s4o, to);
        n_checks++; if (to || ld !== 12'(exp_l)) begin n_fail++; $display("FAIL minw_long got %0d want %0d to=%0b", ld, exp_l, to); end
        exp_l = 0; exp_s = 0;
    endtask

    task automatic test_overflow();
        logic [11:0] ld, sd; logic lo, ls, so, ss, l4o, s4o; logic [3:0] l4d, s4d; bit to;
        for (int i = 0; i < 20; i++) pulse(0, 3, 1'b1, 5);
        read_frame(ld, lo, ls, sd, so, ss, l4d, l4o, s4d, s4o, to);
        n_checks++; if (to || s4d !== 4'd15 || s4o !== 1'b1) begin n_fail++; $display("FAIL ovf_small got %0d/%0b want 15/1", s4d, s4o); end
        n_checks++; if (sd !== 12'(exp_s) || so !== 1'b0) begin n_fail++; $display("FAIL ovf_wide got %0d/%0b want %0d/0", sd, so, exp_s); end
        exp_l = 0; exp_s = 0;
        read_frame(ld, lo, ls, sd, so, ss, l4d, l4o, s4d, s4o, to);
        n_checks++; if (to || s4d !== 4'd0 || s4o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0d/%0b want 0/0", s4d, s4o); end
    endtask

    task automatic test_coincident();
        logic [11:0] ld, sd; logic lo, ls, so, ss, l4o, s4o; logic [3:0] l4d, s4d; bit to;
        logic [5:0] pat;
        for (int i = 0; i < 7; i++) pulse(2, 0, 1'b1, 4);
        // Request lands on the same edge as this pulse's hit.
        disc_local = 1'b1;
        repeat (3) @(negedge clk);
        exp_l++;
        read_frame(ld, lo, ls, sd, so, ss, l4d, l4o, s4d, s4o, to);
        n_checks++; if (to || ld !== 12'(exp_l)) begin n_fail++; $display("FAIL coinc_shadow got %0d want %0d", ld, exp_l); end
        repeat (5) @(negedge clk);
        disc_local = 1'b0;
        repeat (4) @(negedge clk);
        exp_l = 0;
        read_frame(ld, lo, ls, sd, so, ss, l4d, l4o, s4d, s4o, to);
        n_checks++; if (to || ld !== 12'(exp_l)) begin n_fail++; $display("FAIL coinc_next got %0d want %0d", ld, exp_l); end
        // Stall OUT_L for 6 cycles while new pulses arrive.
        for (int i = 0; i < 3; i++) pulse(3, 0, 1'b1, 4);
        rd_ready = 1'b0;
        readout_req = 1'b1;
        @(negedge clk);
        readout_req = 1'b0;
        pat = 6'b011011;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_sel !== 1'b0 || rd_data !== 12'(exp_l)) begin
                n_fail++; $display("FAIL stall_hold cyc%0d got v%0b s%0b d%0d want v1 s0 d%0d", i, rd_valid, rd_sel, rd_data, exp_l);
            end
            disc_local = pat[i];
            @(negedge clk);
        end
        disc_local = 1'b0;
        rd_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (rd_sel !== 1'b1 || rd_data !== 12'd0) begin n_fail++; $display("FAIL stall_sum got s%0b d%0d want s1 d0", rd_sel, rd_data); end
        @(negedge clk);
        rd_ready = 1'b0;
        repeat (5) @(negedge clk);
        exp_l = 2;
        read_frame(ld, lo, ls, sd, so, ss, l4d, l4o, s4d, s4o, to);
        n_checks++; if (to || ld !== 12'(exp_l)) begin n_fail++; $display("FAIL stall_next got %0d want %0d", ld, exp_l); end
        exp_l = 0; exp_s = 0;
    endtask

    task automatic test_shutter();
        logic [11:0] ld, sd; logic lo, ls, so, ss, l4o, s4o; logic [3:0] l4d, s4d; bit to;
        for (int i = 0; i < 3; i++) pulse(3, 3, 1'b0, 5);
        for (int i = 0; i < 2; i++) pulse(3, 3, 1'b1, 5);
        read_frame(ld, lo, ls, sd, so, ss, l4d, l4o, s4d, s4o, to);
        n_checks++; if (to || ld !== 12'(exp_l) || sd !== 12'(exp_s)) begin n_fail++; $display("FAIL shutter got %0d,%0d want %0d,%0d", ld, sd, exp_l, exp_s); end
        n_checks++; if (ls !== 1'b0 || ss !== 1'b1) begin n_fail++; $display("FAIL shutter_sel got %0b,%0b want 0,1", ls, ss); end
        exp_l = 0; exp_s = 0;
    endtask

    task automatic test_random();
        logic [11:0] ld, sd; logic lo, ls, so, ss, l4o, s4o; logic [3:0] l4d, s4d; bit to;
        int sat_l, sat_s;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 24 + f * 16; i++)
                pulse($urandom_range(0, 5), $urandom_range(0, 5), ($urandom_range(0, 3) != 0), $urandom_range(4, 7));
            read_frame(ld, lo, ls, sd, so, ss, l4d, l4o, s4d, s4o, to);
            sat_l = (exp_l > 15) ? 15 : exp_l;
            sat_s = (exp_s > 15) ? 15 : exp_s;
            n_checks++; if (to || ld !== 12'(exp_l) || sd !== 12'(exp_s) || lo !== 1'b0 || so !== 1'b0) begin
                n_fail++; $display("FAIL rand_wide f%0d got %0d,%0d want %0d,%0d", f, ld, sd, exp_l, exp_s);
            end
            n_checks++; if (l4d !== 4'(sat_l) || s4d !== 4'(sat_s) || l4o !== (exp_l > 15) || s4o !== (exp_s > 15)) begin
                n_fail++; $display("FAIL rand_small f%0d got %0d/%0b,%0d/%0b want %0d,%0d", f, l4d, l4o, s4d, s4o, sat_l, sat_s);
            end
            exp_l = 0; exp_s = 0;
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] ld, sd; logic lo, ls, so, ss, l4o, s4o; logic [3:0] l4d, s4d; bit to;
        for (int i = 0; i < 3; i++) pulse(3, 2, 1'b1, 5);
        rd_ready = 1'b1;
        readout_req = 1'b1;
        @(negedge clk);
        readout_req = 1'b0;
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b1 || rd_sel !== 1'b1) begin n_fail++; $display("FAIL rmid_in_sum got v%0b s%0b want v1 s1", rd_valid, rd_sel); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_data !== 12'd0) begin
            n_fail++; $display("FAIL rmid_abort got v%0b b%0b d%0d want v0 b0 d0", rd_valid, busy, rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_ready = 1'b0;
        exp_l = 0; exp_s = 0;
        @(negedge clk);
        read_frame(ld, lo, ls, sd, so, ss, l4d, l4o, s4d, s4o, to);
        n_checks++; if (to || ld !== 12'd0 || sd !== 12'd0) begin n_fail++; $display("FAIL rmid_after got %0d,%0d want 0,0", ld, sd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_width();
        test_overflow();
        test_coincident();
        test_shutter();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
